// File: rtl/glitch_pulser.sv
// glitch_pulser
//   Triggered burst generator for fault-injection. After arming, a synchronised
//   trigger edge starts a burst: an optional delay, then `count` pulses of
//   `width` cycles separated by `gap` cycles.
//
//   State | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for arm; trigger edges ignored
//   ARMED | config latched, waiting for a synchronised trigger edge
//   DELAY | counting delay cycles before the first pulse
//   PULSE | output active for width cycles
//   GAP   | output inactive for gap cycles between pulses
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   arm                 one-cycle arm request; config sampled on this cycle
//   abort               level; returns to IDLE on the next edge
//   trig                asynchronous external trigger
//   delay/width/gap     CNT_W-bit timing config (cycles)
//   count               RPT_W-bit pulses per burst
//   out                 registered glitch output (polarity per ACTIVE_HIGH)
//   armed, busy, done   status: waiting, bursting, end-of-burst strobe

module glitch_pulser #(
    parameter int CNT_W       = 32,
    parameter int RPT_W       = 8,
    parameter bit ACTIVE_HIGH = 1'b1,
    parameter bit TRIG_RISING = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic             abort,
    input  logic             trig,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] width,
    input  logic [CNT_W-1:0] gap,
    input  logic [RPT_W-1:0] count,
    output logic             out,
    output logic             armed,
    output logic             busy,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_GAP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [RPT_W-1:0] RPT_ONE = RPT_W'(1);

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt_q, cnt_nx;
    logic [CNT_W-1:0] dly_q, wid_q, gap_q;
    logic [RPT_W-1:0] rem_q, rem_nx;
    logic             latch_cfg;
    logic             done_nx;

    // Two-flop synchroniser, a history flop, and a registered edge strobe.
    // The registered strobe sets the trigger-to-pulse latency to 3 + delay.
    logic trig_s1, trig_s2, trig_s3, trig_edge_q;
    logic trig_edge_raw;

    assign trig_edge_raw = TRIG_RISING ? (trig_s2 & ~trig_s3) : (~trig_s2 & trig_s3);

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_s1     <= 1'b0;
            trig_s2     <= 1'b0;
            trig_s3     <= 1'b0;
            trig_edge_q <= 1'b0;
        end else begin
            trig_s1     <= trig;
            trig_s2     <= trig_s1;
            trig_s3     <= trig_s2;
            trig_edge_q <= trig_edge_raw;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt_q;
        rem_nx    = rem_q;
        latch_cfg = 1'b0;
        done_nx   = 1'b0;
        if (abort) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (arm) begin
                        state_nx  = S_ARMED;
                        latch_cfg = 1'b1;
                        cnt_nx    = '0;
                    end
                end
                S_ARMED: begin
                    if (trig_edge_q) begin
                        cnt_nx   = '0;
                        state_nx = (dly_q == '0) ? S_PULSE : S_DELAY;
                    end
                end
                S_DELAY: begin
                    if (cnt_q == dly_q - CNT_ONE) begin
                        state_nx = S_PULSE;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_q + CNT_ONE;
                    end
                end
                S_PULSE: begin
                    if (cnt_q == wid_q - CNT_ONE) begin
                        cnt_nx = '0;
                        if (rem_q > RPT_ONE) begin
                            state_nx = S_GAP;
                        end else begin
                            state_nx = S_IDLE;
                            done_nx  = 1'b1;
                        end
                    end else begin
                        cnt_nx = cnt_q + CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_q == gap_q - CNT_ONE) begin
                        state_nx = S_PULSE;
                        cnt_nx   = '0;
                        rem_nx   = rem_q - RPT_ONE;
                    end else begin
                        cnt_nx = cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_nx = S_IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cnt_q <= '0;
            dly_q <= '0;
            wid_q <= '0;
            gap_q <= '0;
            rem_q <= '0;
            out   <= ~ACTIVE_HIGH;
            armed <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            cnt_q <= cnt_nx;
            // Zero width/gap/count would otherwise wrap the terminal compare.
            if (latch_cfg) begin
                dly_q <= delay;
                wid_q <= (width == '0) ? CNT_ONE : width;
                gap_q <= (gap == '0) ? CNT_ONE : gap;
                rem_q <= (count == '0) ? RPT_ONE : count;
            end else begin
                rem_q <= rem_nx;
            end
            // Outputs registered from the next state so they align with it.
            out   <= (state_nx == S_PULSE) ? ACTIVE_HIGH : ~ACTIVE_HIGH;
            armed <= (state_nx == S_ARMED);
            busy  <= (state_nx == S_DELAY) || (state_nx == S_PULSE) || (state_nx == S_GAP);
            done  <= done_nx;
        end
    end

endmodule
